debounce_scheduler: RTL and testbench



---
 rtl/debounce_scheduler.sv | 160 ++++++++++++++++
 tb/tb_debounce_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// Time-multiplexed debouncer bank with a round-robin arbitrated valid/ack event port.
// Optional macro DBN_RISE_ONLY_EN: only rising steady changes raise events (evt_val is always 1).
module debounce_scheduler #(
    parameter  int NUM_IN    = 8,
    parameter  int TOT_SCANS = 4,
    localparam int IDX_W     = $clog2(NUM_IN)
) (
    input  logic              gch_clk,
    input  logic              gch_reset,
    output logic              gch_ready,
    input  logic [NUM_IN-1:0] bouncing,
    output logic [NUM_IN-1:0] steady,
    output logic [IDX_W-1:0]  scan_idx,
    output logic              evt_valid,
    output logic [IDX_W-1:0]  evt_idx,
    output logic              evt_val,
    input  logic              evt_ack,
    output logic              evt_lost
);
    localparam int               CNT_W    = $clog2(TOT_SCANS) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TOT_SCANS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IN - 1);

    typedef enum logic {ST_INIT, ST_SCAN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_init;
    logic [NUM_IN-1:0]   r_sync1;
    logic [NUM_IN-1:0]   r_sb;
    logic [IDX_W-1:0]    r_scan_idx;
    logic [CNT_W-1:0]    r_cnt [NUM_IN];
    logic [NUM_IN-1:0]   r_steady;
    logic [NUM_IN-1:0]   r_pend;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic                r_evt_valid;
    logic [IDX_W-1:0]    r_evt_idx;
    logic                r_evt_val;
    logic                r_evt_lost;

    logic                w_last;
    logic                w_sb_i;
    logic                w_mis;
    logic                w_at_max;
    logic                w_flip;
    logic                w_pend_set;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [NUM_IN-1:0]   w_set_vec;
    logic [NUM_IN-1:0]   w_clr_vec;
    logic                w_grant_vld;
    logic [IDX_W-1:0]    w_grant_idx;
    logic [IDX_W-1:0]    w_j;
    logic                w_arb;

    // Two-flop synchronizer; deliberately left out of reset.
    always_ff @(posedge gch_clk) begin
        r_sync1 <= bouncing;
        r_sb    <= r_sync1;
    end

    always_ff @(posedge gch_clk) begin
        if (gch_reset) r_state <= ST_INIT;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && w_last) w_state_nxt = ST_SCAN;
    end

    always_comb begin
        gch_ready = (r_state == ST_SCAN);
        w_init    = (r_state == ST_INIT);
    end

    assign w_last = (r_scan_idx == IDX_LAST);

    always_ff @(posedge gch_clk) begin
        if (gch_reset) r_scan_idx <= '0;
        else           r_scan_idx <= w_last ? '0 : r_scan_idx + 1'b1;
    end

    // Shared compare/count datapath for the input visited this cycle.
    always_comb begin
        w_sb_i    = r_sb[r_scan_idx];
        w_mis     = (w_sb_i != r_steady[r_scan_idx]);
        w_at_max  = (r_cnt[r_scan_idx] == CNT_MAX);
        w_flip    = !w_init && w_mis && w_at_max;
`ifdef DBN_RISE_ONLY_EN
        w_pend_set = w_flip && w_sb_i;
`else
        w_pend_set = w_flip;
`endif
        w_cnt_nxt = '0;
        if (!w_init && w_mis && !w_at_max) w_cnt_nxt = r_cnt[r_scan_idx] + 1'b1;
        w_set_vec = '0;
        w_set_vec[r_scan_idx] = w_pend_set;
    end

    always_ff @(posedge gch_clk) begin
        r_cnt[r_scan_idx] <= w_cnt_nxt;
    end

    // First pending input at or after rr_ptr, wrapping around.
    always_comb begin
        int j;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_j         = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_IN) j = j - NUM_IN;
            w_j = IDX_W'(j);
            if (!w_grant_vld && r_pend[w_j]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_j;
            end
        end
        w_arb     = !r_evt_valid && w_grant_vld;
        w_clr_vec = '0;
        if (w_arb) w_clr_vec[w_grant_idx] = 1'b1;
    end

    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            r_steady    <= '0;
            r_pend      <= '0;
            r_rr_ptr    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_evt_val   <= 1'b0;
            r_evt_lost  <= 1'b0;
        end else begin
            // A new change on the input being granted keeps its pend bit.
            r_pend     <= (r_pend & ~w_clr_vec) | w_set_vec;
            r_evt_lost <= w_pend_set && r_pend[r_scan_idx];
            if (w_flip) r_steady[r_scan_idx] <= w_sb_i;
            if (w_arb) begin
                r_evt_valid <= 1'b1;
                r_evt_idx   <= w_grant_idx;
`ifdef DBN_RISE_ONLY_EN
                r_evt_val   <= 1'b1;
`else
                r_evt_val   <= r_steady[w_grant_idx];
`endif
                r_rr_ptr    <= (w_grant_idx == IDX_LAST) ? '0 : w_grant_idx + 1'b1;
            end else if (r_evt_valid && evt_ack) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign steady    = r_steady;
    assign scan_idx  = r_scan_idx;
    assign evt_valid = r_evt_valid;
    assign evt_idx   = r_evt_idx;
    assign evt_val   = r_evt_val;
    assign evt_lost  = r_evt_lost;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (NUM_IN=8, TOT_SCANS=4), cycle-exact expectations.
module tb_debounce_scheduler;
    localparam int NUM_IN = 8;
    localparam int IDX_W  = 3;
`ifdef DBN_RISE_ONLY_EN
    localparam bit RISE = 1'b1;
`else
    localparam bit RISE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic [NUM_IN-1:0] bouncing;
    logic [NUM_IN-1:0] steady;
    logic [IDX_W-1:0]  scan_idx;
    logic              evt_valid;
    logic [IDX_W-1:0]  evt_idx;
    logic              evt_val;
    logic              evt_ack;
    logic              evt_lost;

    int n_vec = 0;
    int n_err = 0;
    int lost_cnt = 0;
    int vld_cnt;

    debounce_scheduler #(.NUM_IN(NUM_IN), .TOT_SCANS(4)) dut (
        .gch_clk   (clk),
        .gch_reset (rst),
        .gch_ready (ready),
        .bouncing  (bouncing),
        .steady    (steady),
        .scan_idx  (scan_idx),
        .evt_valid (evt_valid),
        .evt_idx   (evt_idx),
        .evt_val   (evt_val),
        .evt_ack   (evt_ack),
        .evt_lost  (evt_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (evt_lost === 1'b1) lost_cnt++;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset_init();
        bouncing = '0;
        rst = 1'b1;
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_steady", steady, 0);
        chk("rst_scan_idx", scan_idx, 0);
        rst = 1'b0;
        tick(7);
        chk("init_ready_early", ready, 0);
        tick();
        chk("init_ready", ready, 1);
        chk("init_scan_idx", scan_idx, 0);
    endtask

    initial begin
        rst = 1'b1;
        evt_ack = 1'b0;
        bouncing = '0;
        tick(3);

        // Reset and init sweep
        do_reset_init();
        chk("init_evt_lost", evt_lost, 0);

        // Input 3 held high: flips on edge 36 after the drive, event one cycle later
        bouncing[3] = 1'b1;
        tick(35);
        chk("in3_steady_before", steady, 8'h00);
        tick();
        chk("in3_steady_flip", steady, 8'h08);
        chk("in3_valid_before", evt_valid, 0);
        tick();
        chk("in3_valid", evt_valid, 1);
        chk("in3_idx", evt_idx, 3);
        chk("in3_val", evt_val, 1);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("in3_ack_drop", evt_valid, 0);

        // Input 5 glitches every 9 cycles: never reaches five mismatching visits
        vld_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (c % 9 == 0) bouncing[5] = ~bouncing[5];
            tick();
            if (evt_valid === 1'b1) vld_cnt++;
        end
        bouncing[5] = 1'b0;
        tick(20);
        chk("glitch_no_event", vld_cnt, 0);
        chk("glitch_steady", steady, 8'h08);

        // Restart, then input 7 event held so inputs 1 and 6 queue behind it
        do_reset_init();
        bouncing[7] = 1'b1;
        tick(40);
        chk("in7_valid_before", evt_valid, 0);
        tick();
        chk("in7_valid", evt_valid, 1);
        chk("in7_idx", evt_idx, 7);
        bouncing[1] = 1'b1;
        bouncing[6] = 1'b1;
        tick(100);
        chk("queue_held_valid", evt_valid, 1);
        chk("queue_held_idx", evt_idx, 7);
        chk("queue_steady", steady, 8'hC2);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("queue_gap1", evt_valid, 0);
        tick();
        chk("queue_first_valid", evt_valid, 1);
        chk("queue_first_idx", evt_idx, 1);
        chk("queue_first_val", evt_val, 1);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("queue_gap2", evt_valid, 0);
        tick();
        chk("queue_second_valid", evt_valid, 1);
        chk("queue_second_idx", evt_idx, 6);

        // Input 2 rises then falls while its pend is still queued (idx 6 unacked)
        bouncing[2] = 1'b1;
        tick(50);
        chk("in2_rise_steady", steady, 8'hC6);
        chk("in2_rise_no_lost", lost_cnt, 0);
        bouncing[2] = 1'b0;
        tick(50);
        chk("in2_fall_steady", steady, 8'hC2);
        chk("in2_lost_count", lost_cnt, RISE ? 0 : 1);
        chk("in2_held_idx", evt_idx, 6);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("in2_gap", evt_valid, 0);
        tick();
        chk("in2_valid", evt_valid, 1);
        chk("in2_idx", evt_idx, 2);
        chk("in2_val", evt_val, RISE ? 1 : 0);

        // Align to scan_idx 0, start input 4 counting, reset with idx 2 event in flight
        for (int k = 0; k < 8 && scan_idx != 0; k++) tick();
        chk("align_scan_idx", scan_idx, 0);
        bouncing[4] = 1'b1;
        tick(22);
        chk("pre_rst_valid", evt_valid, 1);
        chk("pre_rst_steady4", steady[4], 0);
        do_reset_init();
        vld_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (evt_valid === 1'b1) vld_cnt++;
        end
        chk("post_rst_no_event", vld_cnt, 0);
        chk("post_rst_steady", steady, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
